// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types for the fetch redirect unit: prediction-queue entry, next-PC
// select encoding and the resolved-branch compare helper.
package fetch_redirect_unit_pkg;

    localparam int          PC_W   = 32;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
    } pred_entry_t;

    typedef enum logic [1:0] {
        SEL_REDIRECT = 2'd0,
        SEL_HOLD     = 2'd1,
        SEL_PRED     = 2'd2,
        SEL_SEQ      = 2'd3
    } npc_sel_e;

    // A tracked prediction is wrong if the direction differs, or both agree on
    // taken but the destination does not.
    function automatic logic entry_mispredicts(input pred_entry_t e,
                                               input logic taken,
                                               input logic [PC_W-1:0] target);
        logic wrong_dir;
        logic wrong_tgt;
        wrong_dir = (e.taken != taken);
        wrong_tgt = e.taken && taken && (e.target != target);
        return wrong_dir || wrong_tgt;
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bus of the redirect unit: BHT lookup, EX resolution and the
// PC / IF-ID / statistics outputs. master = environment, slave = unit.
interface fetch_redirect_unit_if #(parameter int STATW = 16);
    import fetch_redirect_unit_pkg::*;

    logic            stall;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            res_valid;
    logic [PC_W-1:0] res_pc;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic [PC_W-1:0] pc;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic            id_pred_taken;
    logic            flush;
    logic            q_full;
    logic [STATW-1:0] stat_branches;
    logic [STATW-1:0] stat_mispredicts;

    modport master (
        output stall, pred_hit, pred_taken, pred_target,
               res_valid, res_pc, res_taken, res_target,
        input  pc, id_valid, id_pc, id_pred_taken, flush, q_full,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  stall, pred_hit, pred_taken, pred_target,
               res_valid, res_pc, res_taken, res_target,
        output pc, id_valid, id_pc, id_pred_taken, flush, q_full,
               stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/fetch_redirect_unit_pred_queue.sv
// In-order queue of in-flight BHT predictions; pointers carry an extra wrap
// bit so full and empty are distinguishable without a separate counter.
module fetch_redirect_unit_pred_queue
    import fetch_redirect_unit_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push_i,
    input  pred_entry_t push_data_i,
    input  logic        pop_i,
    input  logic        clear_i,
    output pred_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(QDEPTH);

    pred_entry_t   mem_q [QDEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state; clear wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless outside the pointer window.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencer: selects PC+4, BHT target or EX redirect, tracks
// in-flight predictions and flushes IF/ID on a resolved mispredict.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4,
    parameter int          STATW    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fetch_redirect_unit_if.slave  bus_if
);
    pred_entry_t     head_s;
    pred_entry_t     push_data_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic            head_match_s;
    logic            pop_s;
    logic            push_s;
    logic            blocked_s;
    logic            mispredict_s;
    logic [PC_W-1:0] redirect_pc_s;
    npc_sel_e        sel_s;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             id_valid_q, id_valid_d;
    logic [PC_W-1:0]  id_pc_q, id_pc_d;
    logic             id_pred_taken_q, id_pred_taken_d;
    logic             flush_q, flush_d;
    logic [STATW-1:0] stat_br_q, stat_br_d;
    logic [STATW-1:0] stat_mp_q, stat_mp_d;

    assign head_match_s  = !q_empty_s && (head_s.pc == bus_if.res_pc);
    assign pop_s         = bus_if.res_valid && head_match_s;
    assign blocked_s     = bus_if.pred_hit && q_full_s && !pop_s;
    assign redirect_pc_s = bus_if.res_taken ? bus_if.res_target : (bus_if.res_pc + PC_INC);
    assign push_s        = bus_if.pred_hit && ((sel_s == SEL_PRED) || (sel_s == SEL_SEQ));
    assign push_data_s   = {pc_q, bus_if.pred_taken, bus_if.pred_target};

    // Branches with no queue entry were BHT misses, i.e. implicitly not-taken.
    always_comb begin
        if (!bus_if.res_valid) begin
            mispredict_s = 1'b0;
        end else if (head_match_s) begin
            mispredict_s = entry_mispredicts(head_s, bus_if.res_taken, bus_if.res_target);
        end else begin
            mispredict_s = bus_if.res_taken;
        end
    end

    // Next-PC source in priority order.
    always_comb begin
        if (mispredict_s) begin
            sel_s = SEL_REDIRECT;
        end else if (bus_if.stall || blocked_s) begin
            sel_s = SEL_HOLD;
        end else if (bus_if.pred_hit && bus_if.pred_taken) begin
            sel_s = SEL_PRED;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    fetch_redirect_unit_pred_queue #(.QDEPTH(QDEPTH)) u_pred_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_i       (pop_s),
        .clear_i     (mispredict_s),
        .head_o      (head_s),
        .full_o      (q_full_s),
        .empty_o     (q_empty_s)
    );

    // PC, IF/ID and statistics next-state.
    always_comb begin
        pc_d            = pc_q;
        id_valid_d      = id_valid_q;
        id_pc_d         = id_pc_q;
        id_pred_taken_d = id_pred_taken_q;
        flush_d         = mispredict_s;
        case (sel_s)
            SEL_REDIRECT: begin
                pc_d       = redirect_pc_s;
                id_valid_d = 1'b0;
            end
            SEL_HOLD: begin
                // A full queue without a stall inserts a bubble instead of holding IF/ID.
                if (!bus_if.stall) begin
                    id_valid_d = 1'b0;
                end else begin
                    id_valid_d = id_valid_q;
                end
            end
            SEL_PRED, SEL_SEQ: begin
                pc_d            = (sel_s == SEL_PRED) ? bus_if.pred_target : (pc_q + PC_INC);
                id_valid_d      = 1'b1;
                id_pc_d         = pc_q;
                id_pred_taken_d = bus_if.pred_hit && bus_if.pred_taken;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
        if (bus_if.res_valid && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + STATW'(1);
        end else begin
            stat_br_d = stat_br_q;
        end
        if (mispredict_s && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + STATW'(1);
        end else begin
            stat_mp_d = stat_mp_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q            <= RESET_PC;
            id_valid_q      <= 1'b0;
            id_pc_q         <= '0;
            id_pred_taken_q <= 1'b0;
            flush_q         <= 1'b0;
            stat_br_q       <= '0;
            stat_mp_q       <= '0;
        end else begin
            pc_q            <= pc_d;
            id_valid_q      <= id_valid_d;
            id_pc_q         <= id_pc_d;
            id_pred_taken_q <= id_pred_taken_d;
            flush_q         <= flush_d;
            stat_br_q       <= stat_br_d;
            stat_mp_q       <= stat_mp_d;
        end
    end

    assign bus_if.pc               = pc_q;
    assign bus_if.id_valid         = id_valid_q;
    assign bus_if.id_pc            = id_pc_q;
    assign bus_if.id_pred_taken    = id_pred_taken_q;
    assign bus_if.flush            = flush_q;
    assign bus_if.q_full           = q_full_s;
    assign bus_if.stat_branches    = stat_br_q;
    assign bus_if.stat_mispredicts = stat_mp_q;

endmodule
